// File: rtl/cakegame_datapath_n.sv
// Datapath for a memory/sequence button game: sequence RAM, play register, timers, score.
// Optional lives counter enabled by defining CAKEGAME_LIVES_EN.
module cakegame_datapath_n #(
    parameter int BTN_W       = 7,
    parameter int DEPTH       = 16,
    parameter int LEVELS      = 4,
    parameter int SHOW_CYC    = 1000,
    parameter int TIMEOUT_CYC = 4000,
    parameter int MAX_POINTS  = 100,
    parameter int LIVES       = 3,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(LEVELS)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [BTN_W-1:0] buttons,
    input  logic [LW-1:0]    level,
    input  logic [AW:0]      seq_len,
    input  logic             wr_en,
    input  logic [LW-1:0]    wr_level,
    input  logic [AW-1:0]    wr_addr,
    input  logic [BTN_W-1:0] wr_data,
    input  logic             clear_reg,
    input  logic             enable_reg,
    input  logic             clear_addr,
    input  logic             enable_addr,
    input  logic             clear_show,
    input  logic             enable_show,
    input  logic             enable_timeout,
    input  logic             clear_points,
    input  logic             enable_points,
    input  logic             lose_life,
    input  logic [1:0]       out_sel,
    output logic             end_seq,
    output logic             correct_play,
    output logic             has_play,
    output logic             end_show,
    output logic             half_show,
    output logic             timeout,
    output logic             game_over,
    output logic [BTN_W-1:0] play,
    output logic [6:0]       points,
    output logic [3:0]       lives
);

    localparam int SW = (SHOW_CYC > 2) ? $clog2(SHOW_CYC) : 1;
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYC - 1);
    localparam logic [SW-1:0] SHOW_HALF = SW'(SHOW_CYC / 2);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [6:0]    PT_MAX    = 7'(MAX_POINTS);

    logic [BTN_W-1:0] mem [LEVELS*DEPTH];
    logic [BTN_W-1:0] mem_out_q;

    logic [AW-1:0]    addr_q, addr_d;
    logic [AW:0]      last_idx;
    logic [BTN_W-1:0] play_reg_q, play_reg_d;
    logic             btn_any;
    logic             any_q, any_d;
    logic             has_play_q, has_play_d;
    logic [SW-1:0]    show_q, show_d;
    logic [TW-1:0]    to_q, to_d;
    logic [6:0]       points_q, points_d;

    // Sequence RAM: no reset, read registered so a same-edge write returns the old word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[{wr_level, wr_addr}] <= wr_data;
        end
        mem_out_q <= mem[{level, addr_q}];
    end

    assign btn_any = |buttons;

    always_comb begin
        last_idx = (seq_len == '0) ? (AW+1)'(DEPTH - 1) : (seq_len - 1'b1);
        end_seq  = ({1'b0, addr_q} == last_idx);

        addr_d = addr_q;
        if (clear_addr) begin
            addr_d = '0;
        end else if (enable_addr) begin
            addr_d = end_seq ? '0 : addr_q + 1'b1;
        end

        play_reg_d = play_reg_q;
        if (clear_reg) begin
            play_reg_d = '0;
        end else if (enable_reg) begin
            play_reg_d = buttons;
        end

        // Clearing the history lets a button that is still held count as a new play.
        any_d      = clear_reg ? 1'b0 : btn_any;
        has_play_d = clear_reg ? 1'b0 : (btn_any & ~any_q);

        show_d = show_q;
        if (clear_show) begin
            show_d = '0;
        end else if (enable_show) begin
            show_d = (show_q == SHOW_LAST) ? '0 : show_q + 1'b1;
        end

        to_d = to_q;
        if (!enable_timeout) begin
            to_d = '0;
        end else if (to_q != TO_LAST) begin
            to_d = to_q + 1'b1;
        end

        points_d = points_q;
        if (clear_points) begin
            points_d = '0;
        end else if (enable_points && (points_q != PT_MAX)) begin
            points_d = points_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            play_reg_q <= '0;
            any_q      <= 1'b0;
            has_play_q <= 1'b0;
            show_q     <= '0;
            to_q       <= '0;
            points_q   <= '0;
        end else begin
            addr_q     <= addr_d;
            play_reg_q <= play_reg_d;
            any_q      <= any_d;
            has_play_q <= has_play_d;
            show_q     <= show_d;
            to_q       <= to_d;
            points_q   <= points_d;
        end
    end

    assign correct_play = (play_reg_q == mem_out_q);
    assign has_play     = has_play_q;
    assign end_show     = (show_q == SHOW_LAST);
    assign half_show    = (show_q >= SHOW_HALF);
    assign timeout      = (to_q == TO_LAST);
    assign points       = points_q;

    always_comb begin
        play = '0;
        case (out_sel)
            2'd1:    play = mem_out_q;
            2'd2:    play = buttons;
            2'd3:    play = play_reg_q;
            default: play = '0;
        endcase
    end

`ifdef CAKEGAME_LIVES_EN
    localparam logic [3:0] LIVES_INIT = 4'(LIVES);
    logic [3:0] lives_q, lives_d;

    // Reload wins over a simultaneous life loss.
    always_comb begin
        lives_d = lives_q;
        if (clear_points) begin
            lives_d = LIVES_INIT;
        end else if (lose_life && (lives_q != 4'd0)) begin
            lives_d = lives_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lives_q <= LIVES_INIT;
        end else begin
            lives_q <= lives_d;
        end
    end

    assign lives     = lives_q;
    assign game_over = (lives_q == 4'd0);
`else
    logic unused_lose_life;
    assign unused_lose_life = lose_life;
    assign lives     = 4'd0;
    assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_cakegame_datapath_n.sv
// Directed self-checking bench for cakegame_datapath_n (default parameters).
module tb_cakegame_datapath_n;

    localparam int BTN_W = 7;
    localparam int AW    = 4;
    localparam int LW    = 2;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [BTN_W-1:0] buttons;
    logic [LW-1:0]    level;
    logic [AW:0]      seq_len;
    logic             wr_en;
    logic [LW-1:0]    wr_level;
    logic [AW-1:0]    wr_addr;
    logic [BTN_W-1:0] wr_data;
    logic             clear_reg, enable_reg, clear_addr, enable_addr;
    logic             clear_show, enable_show, enable_timeout;
    logic             clear_points, enable_points, lose_life;
    logic [1:0]       out_sel;
    logic             end_seq, correct_play, has_play, end_show, half_show, timeout, game_over;
    logic [BTN_W-1:0] play;
    logic [6:0]       points;
    logic [3:0]       lives;

    int n_asrt = 0;
    int n_fail = 0;

`ifdef CAKEGAME_LIVES_EN
    localparam logic [3:0] LIVES_RST = 4'd3;
`else
    localparam logic [3:0] LIVES_RST = 4'd0;
`endif

    cakegame_datapath_n dut (
        .clock(clock), .reset_n(reset_n), .buttons(buttons), .level(level), .seq_len(seq_len),
        .wr_en(wr_en), .wr_level(wr_level), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_reg(clear_reg), .enable_reg(enable_reg),
        .clear_addr(clear_addr), .enable_addr(enable_addr),
        .clear_show(clear_show), .enable_show(enable_show),
        .enable_timeout(enable_timeout),
        .clear_points(clear_points), .enable_points(enable_points),
        .lose_life(lose_life), .out_sel(out_sel),
        .end_seq(end_seq), .correct_play(correct_play), .has_play(has_play),
        .end_show(end_show), .half_show(half_show), .timeout(timeout),
        .game_over(game_over), .play(play), .points(points), .lives(lives)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and return on the following falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wr(input logic [LW-1:0] l, input logic [AW-1:0] a, input logic [BTN_W-1:0] d);
        wr_level = l; wr_addr = a; wr_data = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin : stim
        int pulses, bad, rises;
        logic prev_to;
        logic [3:0] e_addr [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
        logic [3:0] p_addr [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

        reset_n = 1'b0; buttons = '0; level = '0; seq_len = '0;
        wr_en = 1'b0; wr_level = '0; wr_addr = '0; wr_data = '0;
        clear_reg = 1'b0; enable_reg = 1'b0; clear_addr = 1'b0; enable_addr = 1'b0;
        clear_show = 1'b0; enable_show = 1'b0; enable_timeout = 1'b0;
        clear_points = 1'b0; enable_points = 1'b0; lose_life = 1'b0; out_sel = 2'd0;
        repeat (2) @(negedge clock);

        // Reset state
        chk("rst_has_play", 32'(has_play), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_end_show", 32'(end_show), 32'd0);
        chk("rst_half_show", 32'(half_show), 32'd0);
        chk("rst_points", 32'(points), 32'd0);
        chk("rst_lives", 32'(lives), 32'(LIVES_RST));
        chk("rst_game_over", 32'(game_over), 32'd0);
        chk("rst_end_seq", 32'(end_seq), 32'd0);
        chk("rst_play_sel0", 32'(play), 32'd0);
        reset_n = 1'b1;

        // RAM load and read-back
        wr(2'd1, 4'd3, 7'h04);
        wr(2'd0, 4'd3, 7'h55);
        for (int i = 0; i < 5; i++) wr(2'd2, 4'(i), 7'(8'h10 + i));

        level = 2'd1; enable_addr = 1'b1;
        repeat (3) tick();
        enable_addr = 1'b0;
        tick();
        out_sel = 2'd1; #1;
        chk("ram_l1a3", 32'(play), 32'h04);
        buttons = 7'h04; enable_reg = 1'b1;
        tick();
        enable_reg = 1'b0;
        chk("correct_play_hit", 32'(correct_play), 32'd1);
        out_sel = 2'd3; #1;
        chk("play_sel3", 32'(play), 32'h04);
        buttons = 7'h3A; out_sel = 2'd2; #1;
        chk("play_sel2", 32'(play), 32'h3A);
        buttons = '0; out_sel = 2'd1;

        // Level switch keeps addr
        level = 2'd0;
        tick();
        chk("lvl0_read", 32'(play), 32'h55);
        chk("correct_play_miss", 32'(correct_play), 32'd0);
        level = 2'd1;
        tick();
        chk("lvl1_reread", 32'(play), 32'h04);

        // Same-edge write/read returns old word
        wr(2'd1, 4'd3, 7'h22);
        chk("rw_old_word", 32'(play), 32'h04);
        tick();
        chk("rw_new_word", 32'(play), 32'h22);
        out_sel = 2'd0; #1;
        chk("play_sel0", 32'(play), 32'd0);
        out_sel = 2'd1;

        // Address wrap at seq_len=5, clear beats enable
        level = 2'd2; seq_len = 5'd5; clear_addr = 1'b1; enable_addr = 1'b1;
        tick();
        clear_addr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("end_seq_%0d", i), 32'(end_seq), 32'(e_addr[i] == 4'd4));
            chk($sformatf("addr_rd_%0d", i), 32'(play), 32'(8'h10 + p_addr[i]));
        end
        enable_addr = 1'b0;

        // Play edge detection
        buttons = '0;
        tick();
        buttons = 7'h02;
        tick();
        chk("has_play_first", 32'(has_play), 32'd1);
        pulses = 0;
        repeat (9) begin
            tick();
            if (has_play) pulses++;
        end
        chk("has_play_held", 32'(pulses), 32'd0);
        clear_reg = 1'b1; enable_reg = 1'b1;
        tick();
        clear_reg = 1'b0; enable_reg = 1'b0;
        chk("has_play_clr_cycle", 32'(has_play), 32'd0);
        out_sel = 2'd3; #1;
        chk("clear_reg_prio", 32'(play), 32'd0);
        tick();
        chk("has_play_retrig", 32'(has_play), 32'd1);
        tick();
        chk("has_play_retrig_end", 32'(has_play), 32'd0);
        buttons = '0;

        // Show timer
        clear_show = 1'b1;
        tick();
        clear_show = 1'b0; enable_show = 1'b1;
        repeat (499) tick();
        chk("half_show_499", 32'(half_show), 32'd0);
        tick();
        chk("half_show_500", 32'(half_show), 32'd1);
        chk("end_show_500", 32'(end_show), 32'd0);
        repeat (499) tick();
        chk("end_show_999", 32'(end_show), 32'd1);
        tick();
        chk("end_show_wrap", 32'(end_show), 32'd0);
        chk("half_show_wrap", 32'(half_show), 32'd0);
        repeat (600) tick();
        chk("half_show_600", 32'(half_show), 32'd1);
        clear_show = 1'b1;
        tick();
        clear_show = 1'b0; enable_show = 1'b0;
        chk("show_clear_prio", 32'(half_show), 32'd0);

        // Timeout saturation
        enable_timeout = 1'b1;
        bad = 0; rises = 0; prev_to = 1'b0;
        for (int k = 1; k <= 4005; k++) begin
            tick();
            if (timeout !== (k >= 3999)) bad++;
            if (timeout && !prev_to) rises++;
            prev_to = timeout;
        end
        chk("timeout_profile", 32'(bad), 32'd0);
        chk("timeout_rises", 32'(rises), 32'd1);
        chk("timeout_held", 32'(timeout), 32'd1);
        enable_timeout = 1'b0;
        tick();
        chk("timeout_drop", 32'(timeout), 32'd0);

        // Points saturation
        clear_points = 1'b1;
        tick();
        clear_points = 1'b0; enable_points = 1'b1;
        bad = 0;
        for (int k = 1; k <= 120; k++) begin
            tick();
            if (points !== 7'((k < 100) ? k : 100)) bad++;
        end
        enable_points = 1'b0;
        chk("points_profile", 32'(bad), 32'd0);
        chk("points_sat", 32'(points), 32'd100);

        // Lives
        clear_points = 1'b1;
        tick();
        clear_points = 1'b0;
        chk("points_cleared", 32'(points), 32'd0);
`ifdef CAKEGAME_LIVES_EN
        chk("lives_load", 32'(lives), 32'd3);
        for (int i = 2; i >= 0; i--) begin
            lose_life = 1'b1;
            tick();
            lose_life = 1'b0;
            chk($sformatf("lives_%0d", i), 32'(lives), 32'(i));
        end
        chk("game_over", 32'(game_over), 32'd1);
        lose_life = 1'b1;
        tick();
        chk("lives_floor", 32'(lives), 32'd0);
        clear_points = 1'b1;
        tick();
        clear_points = 1'b0; lose_life = 1'b0;
        chk("lives_reload_prio", 32'(lives), 32'd3);
        chk("game_over_clear", 32'(game_over), 32'd0);
`else
        lose_life = 1'b1;
        repeat (3) tick();
        lose_life = 1'b0;
        chk("lives_disabled", 32'(lives), 32'd0);
        chk("game_over_disabled", 32'(game_over), 32'd0);
`endif

        // Asynchronous reset mid-count, RAM kept
        enable_points = 1'b1;
        repeat (10) tick();
        chk("points_10", 32'(points), 32'd10);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_points", 32'(points), 32'd0);
        chk("async_rst_lives", 32'(lives), 32'(LIVES_RST));
        enable_points = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        level = 2'd2; out_sel = 2'd1;
        tick();
        chk("ram_after_reset", 32'(play), 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cakegame_datapath_n.md
CAKEGAME_DATAPATH_N -- requirements
Module: cakegame_datapath_n

Interface
REQ-001 SHALL have parameter BTN_W, default 7, button/play vector width.
REQ-002 SHALL have parameter DEPTH, default 16, sequence entries per level (power of 2); AW = log2(DEPTH).
REQ-003 SHALL have parameter LEVELS, default 4, difficulty levels (power of 2); LW = log2(LEVELS).
REQ-004 SHALL have parameters SHOW_CYC (1000), TIMEOUT_CYC (4000), MAX_POINTS (100), LIVES (3), all cycle/count values >= 2.
REQ-005 SHALL have ports, clock and reset first:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- buttons  in  BTN_W  raw player buttons
- level  in  LW  active difficulty level
- seq_len  in  AW+1  active sequence length; 0 means DEPTH
- wr_en, wr_level, wr_addr, wr_data  in  1/LW/AW/BTN_W  sequence RAM load port
- clear_reg, enable_reg  in  1  play register control
- clear_addr, enable_addr  in  1  sequence address counter control
- clear_show, enable_show  in  1  show timer control
- enable_timeout  in  1  timeout timer run/clear
- clear_points, enable_points  in  1  points counter control
- lose_life  in  1  life decrement request
- out_sel  in  2  play output select
- end_seq, correct_play, has_play, end_show, half_show, timeout, game_over  out  1  status
- play  out  BTN_W  selected display vector
- points  out  7  score
- lives  out  4  remaining lives

Function
REQ-006 Sequence RAM SHALL hold LEVELS x DEPTH words of BTN_W bits, written at the rising edge when wr_en=1 at {wr_level, wr_addr}.
REQ-007 RAM read SHALL be synchronous: mem_out reflects {level, addr} sampled at the previous edge; same-cycle write/read of one location returns the old word.
REQ-008 Address counter SHALL increment on enable_addr, wrap to 0 after seq_len-1 (DEPTH-1 when seq_len=0); clear_addr SHALL have priority over enable_addr.
REQ-009 end_seq SHALL be combinationally 1 when addr equals the last valid index.
REQ-010 has_play SHALL be a one-cycle registered pulse, asserted the cycle after OR(buttons) first goes 1 from 0; held buttons SHALL NOT retrigger; clear_reg SHALL clear the edge history so a still-held button retriggers.
REQ-011 Play register SHALL load buttons on enable_reg; clear_reg has priority and zeroes it.
REQ-012 correct_play SHALL be combinationally 1 iff play register equals mem_out.
REQ-013 Show timer SHALL count 0..SHOW_CYC-1 while enable_show, wrapping; end_show=1 when count=SHOW_CYC-1; half_show=1 when count>=SHOW_CYC/2; clear_show has priority.
REQ-014 Timeout timer SHALL be held at 0 while enable_timeout=0, count while 1, saturate at TIMEOUT_CYC-1 with timeout=1 held until enable_timeout falls.
REQ-015 Points SHALL increment on enable_points, saturating at MAX_POINTS; clear_points has priority.
REQ-016 play SHALL be 0 for out_sel=0, mem_out for 1, buttons for 2, play register for 3.
REQ-017 Changing level mid-sequence SHALL take effect on the next read without altering addr.

Reset
REQ-018 reset_n=0 SHALL asynchronously zero addr, play register, edge history, all timers and points; outputs has_play=0, timeout=0, end_show=0, half_show=0, points=0; lives=LIVES when enabled, else 0.
REQ-019 RAM contents SHALL NOT be cleared by reset; reset mid-game returns all counters to 0 on the same edge without corrupting RAM.

Configuration
REQ-020 With CAKEGAME_LIVES_EN defined: lives loads LIVES on clear_points, decrements by 1 on lose_life, stops at 0; game_over=1 when lives=0; clear_points and lose_life together SHALL reload.
REQ-021 Without CAKEGAME_LIVES_EN: lives=0, game_over=0, lose_life ignored.

Verification
REQ-022 Write level1 addr3=7'h04, level=1, addr stepped to 3 -> mem_out=7'h04 one cycle later; buttons=7'h04, enable_reg -> correct_play=1.
REQ-023 seq_len=5, enable_addr held 6 cycles -> addr 1,2,3,4,0,1; end_seq=1 only at addr=4.
REQ-024 buttons 0->7'h02 held 10 cycles -> has_play exactly one pulse; clear_reg while held -> one further pulse.
REQ-025 enable_timeout=1 for TIMEOUT_CYC+5 cycles -> timeout rises once and stays 1; drop enable -> timeout=0 next cycle.
REQ-026 enable_points for 120 cycles -> points saturates at 100; with CAKEGAME_LIVES_EN, 3 lose_life pulses -> lives 2,1,0 then game_over=1; reset_n=0 mid-count -> points=0 immediately.
